// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage with word-addressed data memory, branch select and MEM/WB latch
module mem_stage #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wb_ctlout,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2out,
  input  logic [4:0]  five_bit_muxout,
  output logic        pcsrc,
  output logic [1:0]  mem_wb_ctl,
  output logic [31:0] read_data,
  output logic [31:0] mem_alu_result,
  output logic [4:0]  mem_write_reg
);
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rd;
  assign idx   = alu_result[ADDR_W+1:2];
  assign rd    = mem[idx];
  assign pcsrc = branch & zero;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      mem_wb_ctl     <= '0;
      read_data      <= '0;
      mem_alu_result <= '0;
      mem_write_reg  <= '0;
    end else begin
      if (memwrite) mem[idx] <= rdata2out;
      mem_wb_ctl     <= wb_ctlout;
      read_data      <= memread ? rd : '0;
      mem_alu_result <= alu_result;
      mem_write_reg  <= five_bit_muxout;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage against a behavioural memory model
module tb_mem_stage;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [1:0]  wb_ctlout = 0;
  logic        branch = 0, memread = 0, memwrite = 0, zero = 0;
  logic [31:0] alu_result = 0, rdata2out = 0;
  logic [4:0]  five_bit_muxout = 0;
  logic        pcsrc;
  logic [1:0]  mem_wb_ctl;
  logic [31:0] read_data, mem_alu_result;
  logic [4:0]  mem_write_reg;
  typedef struct packed {
    logic [1:0]  ctl;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  rg;
  } exp_t;
  exp_t        q[$];
  exp_t        got, want;
  logic [31:0] ref_mem [256];
  int          checks = 0, failures = 0;
  mem_stage #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .wb_ctlout(wb_ctlout), .branch(branch),
    .memread(memread), .memwrite(memwrite), .zero(zero),
    .alu_result(alu_result), .rdata2out(rdata2out),
    .five_bit_muxout(five_bit_muxout), .pcsrc(pcsrc),
    .mem_wb_ctl(mem_wb_ctl), .read_data(read_data),
    .mem_alu_result(mem_alu_result), .mem_write_reg(mem_write_reg)
  );
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic [1:0] wb, input logic br, input logic z,
                      input logic mr, input logic mw, input logic [31:0] a,
                      input logic [31:0] d, input logic [4:0] rg);
    exp_t e;
    int   ix;
    @(negedge clk);
    rst_n = r; wb_ctlout = wb; branch = br; zero = z; memread = mr; memwrite = mw;
    alu_result = a; rdata2out = d; five_bit_muxout = rg;
    ix = int'((a / 4) % 256);
    if (!r) begin
      e = '0;
      foreach (ref_mem[i]) ref_mem[i] = 0;
    end else begin
      e.ctl = wb;
      e.rd  = mr ? ref_mem[ix] : 32'h0;
      e.alu = a;
      e.rg  = rg;
      if (mw) ref_mem[ix] = d;
    end
    q.push_back(e);
    #1;
    checks++;
    if (pcsrc !== (br & z)) begin
      failures++;
      $display("FAIL pcsrc br=%0b z=%0b rst_n=%0b got=%0b want=%0b", br, z, r, pcsrc, br & z);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      want = q.pop_front();
      got  = {mem_wb_ctl, read_data, mem_alu_result, mem_write_reg};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL memwb got ctl=%b rd=%h alu=%h reg=%0d want ctl=%b rd=%h alu=%h reg=%0d",
                 got.ctl, got.rd, got.alu, got.rg, want.ctl, want.rd, want.alu, want.rg);
      end
    end
  end
  initial begin
    foreach (ref_mem[i]) ref_mem[i] = 0;
    step(0, 2'b11, 1, 1, 1, 1, 32'h10, 32'h99, 5'd3);
    step(1, 0, 0, 0, 0, 1, 32'h0C, 32'hDEAD_BEEF, 0);
    step(0, 2'b11, 1, 0, 1, 1, 32'h0C, 32'h77, 5'd9);
    step(1, 0, 0, 1, 1, 0, 32'h0C, 0, 0);
    step(1, 0, 0, 0, 0, 1, 32'h10, 32'h1234_5678, 0);
    step(1, 2'b11, 0, 0, 1, 0, 32'h10, 0, 5'd8);
    step(1, 0, 0, 0, 0, 1, 32'h10, 32'hA, 0);
    step(1, 2'b01, 0, 0, 1, 1, 32'h10, 32'hB, 5'd2);
    step(1, 2'b01, 0, 0, 1, 0, 32'h10, 0, 5'd2);
    step(1, 0, 0, 0, 0, 1, 32'h0000_0403, 32'h55, 0);
    step(1, 2'b01, 0, 0, 1, 0, 32'h0, 0, 5'd31);
    step(1, 2'b10, 1, 1, 0, 0, 32'hFFFF_FFFE, 32'hCAFE, 5'd4);
    step(1, 2'b01, 0, 0, 1, 0, 32'hFFFF_FFFC, 0, 5'd4);
    step(0, 0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 3) == 0 ? 22'($urandom) : 22'd0, 6'($urandom_range(0, 15)), 2'($urandom)};
      a = a << 2 | 32'($urandom_range(0, 3));
      step($urandom_range(0, 39) != 0, 2'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), a, $urandom, 5'($urandom));
    end
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory (MEM) stage of the five-stage MIPS pipeline. It consumes the EX/MEM latch outputs produced by the execute stage, performs the data-memory load or store, generates the branch-taken select (PCSrc) back to the fetch stage, and registers the MEM/WB latch feeding write-back. It holds a word-addressed data memory with synchronous write, combinational read, and a one-cycle MEM/WB pipeline register.

## Interface
- DEPTH, 256, number of 32-bit words in data memory (power of two)
- ADDR_W, 8, word-index width; log2(DEPTH)

- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- wb_ctlout  input  2  WB control from EX/MEM; [1]=regwrite, [0]=memtoreg
- branch  input  1  branch instruction in MEM
- memread  input  1  load request
- memwrite  input  1  store request
- zero  input  1  ALU zero flag from EX/MEM
- alu_result  input  32  byte address for loads/stores; pass-through value for ALU ops
- rdata2out  input  32  store data
- five_bit_muxout  input  5  destination register number
- pcsrc  output  1  branch & zero; selects EX_MEM_NPC in fetch
- mem_wb_ctl  output  2  registered wb_ctlout
- read_data  output  32  registered load data
- mem_alu_result  output  32  registered alu_result
- mem_write_reg  output  5  registered five_bit_muxout

## Operation
- Word index = alu_result[ADDR_W+1:2]; bits [1:0] are ignored (no misalignment trap); bits above ADDR_W+1 are ignored, so addresses wrap modulo DEPTH*4 bytes.
- pcsrc = branch & zero, purely combinational, with no dependence on clk or rst_n.
- Store: on a rising edge with rst_n=1 and memwrite=1, mem[index] <= rdata2out.
- Load: the read port is combinational from the array. The value captured into read_data is mem[index] when memread=1, and 32'h0 when memread=0.
- memread and memwrite both asserted: the write occurs, and read_data captures the pre-write contents (read-before-write).
- MEM/WB latch: on every rising edge with rst_n=1, mem_wb_ctl<=wb_ctlout, mem_alu_result<=alu_result, mem_write_reg<=five_bit_muxout, and read_data as above. There is no enable or stall.
- The block does not interpret the WB controls. It does not check that writes target register 0, because write-back owns that.

## Timing
- Reset (rst_n=0 at a rising edge):
  - mem_wb_ctl=2'b00, read_data=0, mem_alu_result=0, mem_write_reg=0.
  - All DEPTH memory words are cleared to 0 in that same edge.
  - Any memwrite during reset is suppressed.
- pcsrc has no reset value; it follows its inputs at all times, including during reset.
- Latency is 1 cycle: inputs presented in cycle N appear on the MEM/WB outputs after the edge ending cycle N.
- Store-to-load: a store at the edge ending cycle N is visible to a load presented in cycle N+1 to the same index.
- Reset mid-operation: a store coinciding with the reset edge is lost. Memory and all latch outputs read 0 in the next cycle, and operation resumes normally on the first edge with rst_n=1.
- Every input is sampled only at the rising edge; input changes between edges affect only pcsrc and the combinational read.

## Test plan
- Reset: write mem[3]=32'hDEAD_BEEF, then hold rst_n=0 for one edge -> all four latch outputs are 0. A following load from 0x0C gives read_data=0.
- Store then load:
  - Cycle 0: memwrite=1, alu_result=0x10, rdata2out=32'h1234_5678.
  - Cycle 1: memread=1, alu_result=0x10, wb_ctlout=2'b11, five_bit_muxout=5'd8.
  - Required after the cycle-1 edge: read_data=32'h1234_5678, mem_wb_ctl=2'b11, mem_write_reg=8, mem_alu_result=0x10.
- Simultaneous read/write: mem[4]=32'hA, then memread=memwrite=1, alu_result=0x10, rdata2out=32'hB.
  - Required: read_data=32'hA after the edge.
  - A load in the next cycle returns 32'hB.
- Address wrap/misalignment: store 32'h55 at alu_result=0x0000_0403 (DEPTH=256) -> a load at 0x0 returns 32'h55.
- Branch: branch=1,zero=1 -> pcsrc=1 immediately. branch=1,zero=0 -> 0. branch=0,zero=1 -> 0. The same results hold with rst_n=0.
- ALU pass-through: memread=0, memwrite=0, alu_result=32'hFFFF_FFFE, wb_ctlout=2'b10 -> read_data=0, mem_alu_result=32'hFFFF_FFFE, memory unchanged.
